// File: rtl/deint_pkg.sv
// Shared types, constants and delay-line geometry for the convolutional deinterleaver.
package deint_pkg;

    typedef enum logic {HUNT, LOCKED} fsm_t;

    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] SYNC_INV  = 8'hB8;

    localparam int unsigned M_DEF        = 17;
    localparam int unsigned BRANCHES_DEF = 12;
    localparam int unsigned PKT_LEN_DEF  = 204;
    localparam int unsigned MISS_MAX_DEF = 3;

    // Branch j delays by (branches-1-j)*m bytes; the last branch is a bypass.
    function automatic int unsigned branch_len(int unsigned j, int unsigned m, int unsigned branches);
        return (branches - 1 - j) * m;
    endfunction

    function automatic int unsigned branch_base(int unsigned j, int unsigned m, int unsigned branches);
        int unsigned base;
        base = 0;
        for (int unsigned k = 0; k < j; k++) base += branch_len(k, m, branches);
        return base;
    endfunction

    function automatic int unsigned ram_depth(int unsigned m, int unsigned branches);
        return branch_base(branches - 1, m, branches);
    endfunction

    function automatic int unsigned fill_bytes(int unsigned m, int unsigned branches);
        return (branches - 1) * m * branches;
    endfunction

    localparam int unsigned FILL_BYTES = fill_bytes(M_DEF, BRANCHES_DEF);

    function automatic logic is_sync(logic [7:0] d);
        return (d == SYNC_BYTE) || (d == SYNC_INV);
    endfunction

endpackage

// File: rtl/deinterleaver_if.sv
// Byte-stream bus of the deinterleaver: rdy/acpt input and output plus sync status.
interface deinterleaver_if;
    logic       di_rdy;
    logic [7:0] di;
    logic       di_acpt;
    logic       do_rdy;
    logic [7:0] do_data;
    logic       do_acpt;
    logic       sync_lock;
    logic       sync_err;

    modport slave  (input  di_rdy, di, do_acpt,
                    output di_acpt, do_rdy, do_data, sync_lock, sync_err);
    modport master (output di_rdy, di, do_acpt,
                    input  di_acpt, do_rdy, do_data, sync_lock, sync_err);
endinterface

// File: rtl/deint_delay_ram.sv
// Shared RAM holding all branch delay lines; each region has its own circular pointer.
module deint_delay_ram
    import deint_pkg::*;
#(
    parameter int unsigned M        = M_DEF,
    parameter int unsigned BRANCHES = BRANCHES_DEF,
    parameter int unsigned BW       = $clog2(BRANCHES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [BW-1:0] branch,
    input  logic          we,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);
    localparam int unsigned DEPTH  = ram_depth(M, BRANCHES);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = $clog2(branch_len(0, M, BRANCHES));
    localparam int unsigned NLINES = BRANCHES - 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] ptr [NLINES];
    logic [AW-1:0] addr;

    always_comb begin
        addr = '0;
        for (int unsigned i = 0; i < NLINES; i++)
            if (branch == BW'(i)) addr = AW'(branch_base(i, M, BRANCHES)) + AW'(ptr[i]);
    end

    // Asynchronous read gives the old byte in the same cycle the new one is written.
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NLINES; i++) begin
            if (reset || clr)
                ptr[i] <= '0;
            else if (we && branch == BW'(i))
                ptr[i] <= (ptr[i] == PW'(branch_len(i, M, BRANCHES) - 1)) ? '0 : ptr[i] + PW'(1);
        end
    end

endmodule

// File: rtl/deinterleaver.sv
// Convolutional deinterleaver: sync acquisition, commutator counters and registered output.
module deinterleaver
    import deint_pkg::*;
#(
    parameter int unsigned M        = M_DEF,
    parameter int unsigned BRANCHES = BRANCHES_DEF,
    parameter int unsigned PKT_LEN  = PKT_LEN_DEF,
    parameter int unsigned MISS_MAX = MISS_MAX_DEF
) (
    input  logic           clk,
    input  logic           reset,
    deinterleaver_if.slave bus
);
    localparam int unsigned FILL = fill_bytes(M, BRANCHES);
    localparam int unsigned BW   = $clog2(BRANCHES);
    localparam int unsigned PCW  = $clog2(PKT_LEN);
    localparam int unsigned FW   = $clog2(FILL + 1);
    localparam int unsigned MW   = $clog2(MISS_MAX + 1);

    fsm_t           state_q, state_d;
    logic [BW-1:0]  b_q;
    logic [PCW-1:0] p_q;
    logic [FW-1:0]  fill_q;
    logic [MW-1:0]  miss_q;
    logic           in_hs, out_hs, take, miss, lose, load, line_we;
    logic [7:0]     ram_dout;

    assign bus.di_acpt   = ~reset & (~bus.do_rdy | bus.do_acpt);
    assign in_hs         = bus.di_rdy & bus.di_acpt;
    assign out_hs        = bus.do_rdy & bus.do_acpt;
    assign bus.sync_lock = (state_q == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) state_q <= HUNT;
        else       state_q <= state_d;
    end

    // take: the byte enters the commutator; a lock-losing byte is dropped instead.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        miss    = 1'b0;
        lose    = 1'b0;
        case (state_q)
            HUNT: begin
                if (in_hs && is_sync(bus.di)) begin
                    state_d = LOCKED;
                    take    = 1'b1;
                end
            end
            LOCKED: begin
                if (in_hs) begin
                    if (p_q == '0 && !is_sync(bus.di)) miss = 1'b1;
                    if (miss && miss_q == MW'(MISS_MAX - 1)) begin
                        lose    = 1'b1;
                        state_d = HUNT;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign load    = take && (fill_q == FW'(FILL));
    assign line_we = take && (b_q != BW'(BRANCHES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            b_q          <= '0;
            p_q          <= '0;
            fill_q       <= '0;
            miss_q       <= '0;
            bus.sync_err <= 1'b0;
        end else begin
            bus.sync_err <= miss;
            if (lose) begin
                b_q    <= '0;
                p_q    <= '0;
                fill_q <= '0;
                miss_q <= '0;
            end else if (take) begin
                b_q <= (b_q == BW'(BRANCHES - 1)) ? '0 : b_q + BW'(1);
                p_q <= (p_q == PCW'(PKT_LEN - 1)) ? '0 : p_q + PCW'(1);
                if (fill_q != FW'(FILL)) fill_q <= fill_q + FW'(1);
                if (p_q == '0) miss_q <= miss ? miss_q + MW'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.do_rdy  <= 1'b0;
            bus.do_data <= '0;
        end else if (load) begin
            bus.do_rdy  <= 1'b1;
            bus.do_data <= (b_q == BW'(BRANCHES - 1)) ? bus.di : ram_dout;
        end else if (out_hs) begin
            bus.do_rdy  <= 1'b0;
        end
    end

    deint_delay_ram #(
        .M        (M),
        .BRANCHES (BRANCHES),
        .BW       (BW)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .clr    (lose),
        .branch (b_q),
        .we     (line_we),
        .din    (bus.di),
        .dout   (ram_dout)
    );

endmodule

// File: doc/deinterleaver.md
Name: deinterleaver

Overview:
- Byte-wide convolutional deinterleaver (I=12 branches, M=17 bytes). It is the receive-side inverse of the team's 204-byte-packet interleaver.
- Input is an interleaved byte stream that carries a sync byte (0x47 or 0xB8) on branch 0 every 204 bytes.
- It acquires sync, routes each byte through its branch delay line, and emits the de-interleaved packet stream.
- Both input and output use the codebase rdy/acpt handshake. It sits between the channel-side receiver and the packet sink.

Parameters:
- M, 17, branch delay unit in bytes.
- BRANCHES, 12, number of commutator branches.
- PKT_LEN, 204, packet length in bytes; must equal BRANCHES*M.
- MISS_MAX, 3, consecutive missed syncs before lock is lost.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  reset; synchronous, active-high.
- di_rdy  in  1  upstream byte valid.
- di  in  8  upstream byte.
- di_acpt  out  1  deinterleaver accepts di this cycle.
- do_rdy  out  1  output byte valid.
- do_data  out  8  output byte.
- do_acpt  in  1  downstream accepts do_data.
- sync_lock  out  1  high while locked.
- sync_err  out  1  one-cycle pulse on each missed sync check while locked.

Behaviour:
- Reset (sync, active-high): do_rdy=0, do_data=0, sync_lock=0, sync_err=0, FSM=HUNT, all counters and pointers=0. RAM contents are not cleared. Reset wins over any same-cycle handshake.
- Handshakes:
  - in_hs = di_rdy & di_acpt.
  - out_hs = do_rdy & do_acpt.
  - di_acpt = ~reset & (~do_rdy | do_acpt), combinational. Throughput is 1 byte/clk.
  - do_rdy/do_data are registered. Once do_rdy=1, do_data holds stable until out_hs.
- FSM states:
  - HUNT: every in_hs byte is accepted and dropped. If the byte is 0x47 or 0xB8, go to LOCKED. That byte is treated as branch 0, position 0. It is written into branch 0's delay line.
  - LOCKED: a per-byte branch counter b runs 0..11 and wraps. A packet position counter p runs 0..203 and wraps.
  - Sync check: at each in_hs with p==0, check for a sync byte. On a miss, pulse sync_err the next cycle and increment the miss counter. On a hit, clear the miss counter.
  - On the MISS_MAX-th consecutive miss, go to HUNT and clear b, p, the fill counter and the pointers. A pending do_rdy byte still completes its handshake.
- Delay lines:
  - Branch j (0..10) delays by (11-j)*M bytes. Branch 11 is bypass.
  - Storage is one single-port-per-cycle RAM of M*66 = 1122 bytes. Region j is based at M*sum_{k<j}(11-k) with length (11-j)*M.
  - Each region has its own pointer. On in_hs for branch j, read the old byte at the pointer, write di at the same address, then advance the pointer. It wraps from length-1 to 0.
  - For branch 11, di goes directly to the output register.
- Fill:
  - A 12-bit fill counter counts in_hs while LOCKED and saturates at 2244 (11*M*12).
  - While fill<2244, the data read out of the RAM is discarded and do_rdy stays 0.
  - Once saturated, every in_hs loads the output register one cycle later. The first output byte is the delayed sync byte.
- Simultaneous events:
  - out_hs and in_hs in the same cycle: the register reloads with no bubble.
  - A sync miss and lock loss in the same cycle as in_hs: that byte is dropped.

Decomposition:
- Package deint_pkg holds:
  - fsm enum {HUNT, LOCKED};
  - constants SYNC_BYTE=8'h47 and SYNC_INV=8'hB8;
  - branch base/length table as functions of M;
  - FILL_BYTES.
- One sub-module, deint_delay_ram: 1122x8 RAM plus the 11 pointers and wrap logic. Inputs are branch, we, din; output is dout (read-before-write).

Test Plan:
- Reset: assert reset 2 cycles mid-traffic -> next cycle do_rdy=0, sync_lock=0, di_acpt=0 during reset; no output until relocked and refilled.
- Acquisition: 5 bytes of 0x00 then 0x47 -> first 5 accepted and dropped; sync_lock=1 the cycle after the 0x47 handshake.
- Round trip: 20 packets (sync 0x47, or 0xB8 every 8th packet; payload byte k = k mod 256) passed through the team interleaver into this block with do_acpt=1 -> do_rdy first rises after 2244 accepted bytes. Output equals the original packets bit-exact from packet 0, and a sync appears every 204 output bytes.
- Backpressure: same stream with do_acpt random 50% -> di_acpt tracks ~do_rdy|do_acpt; no byte lost or duplicated; identical output sequence.
- Sync loss: one corrupted sync -> single sync_err pulse, lock held. Three consecutive corrupted syncs -> 3 pulses, then sync_lock=0 and output stops after the pending byte drains. Relock on the next valid sync, then refill to 2244.
- Pointer wrap: stream 50 packets -> branch 0 pointer wraps at 187 and branch 10 wraps at 17 with no corruption; output stays correct.
